bcd_convert_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It generalises the combinational 8-bit display decoder to arbitrary input width, digit count and signed input, and adds a start/done handshake and overflow saturation. It sits between the datapath result registers and the seven-segment digit multiplexer; the BCD output is held stable between conversions.

---
 rtl/bcd_convert_seq.sv | 135 +++++++++++++
 tb/tb_bcd_convert_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_seq
// Purpose  : Sequential binary-to-BCD converter (shift-and-add-3, one input
//            bit per clock) with start/done handshake, optional signed
//            input and overflow saturation. Results are held between
//            conversions.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset
//            i_start  - conversion request, honoured in IDLE or DONE
//            i_bin    - value to convert, sampled with an accepted start
//            o_busy   - conversion in progress
//            o_done   - one-cycle pulse, results updated in the same cycle
//            o_bcd    - result digits, ones digit in bits [3:0]
//            o_neg    - sign of last converted value (0 when unsigned)
//            o_ovf    - last value exceeded 10^DIGITS-1, o_bcd saturated
// Revision : 1.0 - initial release
// ============================================================================
module bcd_convert_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [WIDTH-1:0]      i_bin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_neg,
   output logic                  o_ovf
);

   localparam int                 CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]      c_last = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      c_cnt1 = CW'(1);
   localparam logic [WIDTH-1:0]   c_one  = WIDTH'(1);
   localparam logic [4*DIGITS-1:0] c_sat = {DIGITS{4'd9}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   logic [WIDTH-1:0]      r_shift;
   logic [4*DIGITS-1:0]   r_acc;
   logic [CW-1:0]         r_cnt;
   logic                  r_sign;
   logic                  r_ovf;

   logic [4*DIGITS-1:0]   w_adj;
   logic [4*DIGITS-1:0]   w_acc_next;
   logic [WIDTH-1:0]      w_shift_next;
   logic                  w_ovf_bit;
   logic                  w_is_neg;
   logic [WIDTH-1:0]      w_mag;

   // Add-3 correction: every digit evaluated from its pre-add value.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign w_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ? (r_acc[4*g +: 4] + 4'd3)
                                                         : r_acc[4*g +: 4];
   end

   // Shift {acc, shift} left by one; the bit falling off the top digit
   // means the value no longer fits in DIGITS digits.
   assign w_ovf_bit    = w_adj[4*DIGITS-1];
   assign w_acc_next   = {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
   assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};

   // Two's complement magnitude; the most negative value maps to
   // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit number.
   assign w_is_neg = (SIGNED != 0) && i_bin[WIDTH-1];
   assign w_mag    = w_is_neg ? (~i_bin + c_one) : i_bin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_sign  <= 1'b0;
         r_ovf   <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_bcd   <= '0;
         o_neg   <= 1'b0;
         o_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  r_shift <= w_mag;
                  r_sign  <= w_is_neg;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= '0;
                  o_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end else begin
                  r_state <= S_IDLE;
               end
            end

            S_SHIFT: begin
               r_shift <= w_shift_next;
               r_acc   <= w_acc_next;
               r_ovf   <= r_ovf | w_ovf_bit;
               r_cnt   <= r_cnt + c_cnt1;
               if (r_cnt == c_last) begin
                  // Last bit: publish the fully shifted result directly so
                  // the outputs change on the same edge DONE is entered.
                  o_bcd   <= (r_ovf | w_ovf_bit) ? c_sat : w_acc_next;
                  o_ovf   <= r_ovf | w_ovf_bit;
                  o_neg   <= r_sign;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end

            default: begin
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_convert_seq
// Purpose  : Directed self-checking bench for bcd_convert_seq. Three
//            instances cover 16-bit/5-digit unsigned, 16-bit/4-digit
//            unsigned (overflow) and 8-bit/3-digit signed configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        sa = 1'b0, sb = 1'b0, sc = 1'b0;
   logic [15:0] bina = '0, binb = '0;
   logic [7:0]  binc = '0;

   logic        busy_a, done_a, neg_a, ovf_a;
   logic        busy_b, done_b, neg_b, ovf_b;
   logic        busy_c, done_c, neg_c, ovf_c;
   logic [19:0] bcd_a;
   logic [15:0] bcd_b;
   logic [11:0] bcd_c;

   int          checks = 0;
   int          errors = 0;
   int          sel = 0;

   logic        cur_busy, cur_done, cur_neg, cur_ovf;
   logic [31:0] cur_bcd;

   always #5 clk = ~clk;

   bcd_convert_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_a (
      .clk(clk), .rst_n(rst_n), .i_start(sa), .i_bin(bina),
      .o_busy(busy_a), .o_done(done_a), .o_bcd(bcd_a), .o_neg(neg_a), .o_ovf(ovf_a));

   bcd_convert_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(0)) u_b (
      .clk(clk), .rst_n(rst_n), .i_start(sb), .i_bin(binb),
      .o_busy(busy_b), .o_done(done_b), .o_bcd(bcd_b), .o_neg(neg_b), .o_ovf(ovf_b));

   bcd_convert_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_c (
      .clk(clk), .rst_n(rst_n), .i_start(sc), .i_bin(binc),
      .o_busy(busy_c), .o_done(done_c), .o_bcd(bcd_c), .o_neg(neg_c), .o_ovf(ovf_c));

   always_comb begin
      cur_busy = busy_a; cur_done = done_a; cur_neg = neg_a; cur_ovf = ovf_a;
      cur_bcd  = {12'd0, bcd_a};
      case (sel)
         1: begin
            cur_busy = busy_b; cur_done = done_b; cur_neg = neg_b; cur_ovf = ovf_b;
            cur_bcd  = {16'd0, bcd_b};
         end
         2: begin
            cur_busy = busy_c; cur_done = done_c; cur_neg = neg_c; cur_ovf = ovf_c;
            cur_bcd  = {20'd0, bcd_c};
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v, input logic [15:0] b);
      case (sel)
         0: begin sa = v; bina = b; end
         1: begin sb = v; binb = b; end
         default: begin sc = v; binc = b[7:0]; end
      endcase
   endtask

   // Issue a one-cycle start; returns #1 after the accepting edge.
   task automatic start_conv(input logic [15:0] b);
      set_start(1'b1, b);
      @(posedge clk); #1;
      set_start(1'b0, b);
   endtask

   // Count edges until DONE, the BUSY cycles seen and whether BCD changed
   // before DONE. Bounded so a dead DUT cannot hang the run.
   task automatic wait_done(output int n, output int busy_n, output logic held);
      logic [31:0] prev;
      prev   = cur_bcd;
      held   = 1'b1;
      n      = 0;
      busy_n = cur_busy ? 1 : 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (cur_done) break;
         if (cur_busy) busy_n++;
         if (cur_bcd !== prev) held = 1'b0;
      end
      check("done_busy_exclusive", {31'd0, cur_busy & cur_done}, 32'd0);
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (cur_done) cnt++;
      end
   endtask

   initial begin
      int   n, bn, cnt;
      logic held;

      // ---------------- reset ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_done_a", {31'd0, done_a}, 32'd0);
      check("rst_bcd_a",  {12'd0, bcd_a}, 32'd0);
      check("rst_flags_c", {30'd0, neg_c, ovf_c}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---------------- A: zero ----------------
      sel = 0;
      start_conv(16'd0);
      check("zero_busy_after_accept", {31'd0, cur_busy}, 32'd1);
      wait_done(n, bn, held);
      check("zero_latency", n, 32'd16);
      check("zero_busy_cycles", bn, 32'd16);
      check("zero_bcd", cur_bcd, 32'h00000);
      check("zero_ovf", {31'd0, cur_ovf}, 32'd0);
      @(posedge clk); #1;
      check("zero_done_pulse_width", {31'd0, cur_done}, 32'd0);
      check("zero_idle_busy", {31'd0, cur_busy}, 32'd0);

      // ---------------- A: max and hold ----------------
      start_conv(16'd65535);
      wait_done(n, bn, held);
      check("max_bcd", cur_bcd, 32'h65535);
      check("max_ovf", {31'd0, cur_ovf}, 32'd0);
      repeat (2) @(posedge clk); #1;
      start_conv(16'd40960);
      bina = 16'd1;  // changes mid-conversion must not matter
      wait_done(n, bn, held);
      check("hold_prev_bcd", {31'd0, held}, 32'd1);
      check("b40960_bcd", cur_bcd, 32'h40960);

      // ---------------- B: overflow ----------------
      sel = 1;
      start_conv(16'd12345);
      wait_done(n, bn, held);
      check("ovf_flag", {31'd0, cur_ovf}, 32'd1);
      check("ovf_sat_bcd", cur_bcd, 32'h9999);
      start_conv(16'd9999);
      wait_done(n, bn, held);
      check("9999_ovf", {31'd0, cur_ovf}, 32'd0);
      check("9999_bcd", cur_bcd, 32'h9999);

      // ---------------- C: signed ----------------
      sel = 2;
      start_conv(16'h0080);
      wait_done(n, bn, held);
      check("s80_latency", n, 32'd8);
      check("s80_neg", {31'd0, cur_neg}, 32'd1);
      check("s80_bcd", cur_bcd, 32'h128);
      start_conv(16'h00FF);
      wait_done(n, bn, held);
      check("sFF_neg", {31'd0, cur_neg}, 32'd1);
      check("sFF_bcd", cur_bcd, 32'h001);
      start_conv(16'h007F);
      wait_done(n, bn, held);
      check("s7F_neg", {31'd0, cur_neg}, 32'd0);
      check("s7F_bcd", cur_bcd, 32'h127);
      start_conv(16'h0000);
      wait_done(n, bn, held);
      check("s00_neg", {31'd0, cur_neg}, 32'd0);
      check("s00_bcd", cur_bcd, 32'h000);

      // ---------------- A: start during SHIFT ignored ----------------
      sel = 0;
      start_conv(16'd1234);
      repeat (4) @(posedge clk);
      #1;
      set_start(1'b1, 16'd999);
      @(posedge clk); #1;
      set_start(1'b0, 16'd0);
      wait_done(n, bn, held);
      check("ignore_latency", n, 32'd11);
      check("ignore_bcd", cur_bcd, 32'h01234);
      count_done(20, cnt);
      check("ignore_no_second_done", cnt, 32'd0);

      // ---------------- A: back-to-back through DONE ----------------
      start_conv(16'd500);
      wait_done(n, bn, held);
      check("b2b_first_bcd", cur_bcd, 32'h00500);
      set_start(1'b1, 16'd321);
      @(posedge clk); #1;
      set_start(1'b0, 16'd0);
      check("b2b_no_idle_busy", {31'd0, cur_busy}, 32'd1);
      wait_done(n, bn, held);
      check("b2b_latency", n, 32'd16);
      check("b2b_second_bcd", cur_bcd, 32'h00321);

      // ---------------- A: reset mid-conversion ----------------
      start_conv(16'd4321);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, cur_busy}, 32'd0);
      check("abort_done", {31'd0, cur_done}, 32'd0);
      check("abort_bcd", cur_bcd, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      count_done(20, cnt);
      check("abort_no_done", cnt, 32'd0);
      start_conv(16'd1000);
      wait_done(n, bn, held);
      check("post_reset_bcd", cur_bcd, 32'h01000);
      check("post_reset_latency", n, 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog: the directed sequence is far shorter than this.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
